// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register file.
package regfile_pkg;

  localparam int unsigned REG_COUNT  = 32;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: enable gating, x0 masking and the optional
// write-to-read forwarding mux (compiled in with REGFILE_BYPASS_EN).
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = XLEN,
  parameter int unsigned ADDR_WIDTH = REG_ADDR_W
) (
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] stored_data,
  // Write that commits at the next edge; byp_valid already excludes x0 and reset.
  input  logic                  byp_valid,
  input  logic [ADDR_WIDTH-1:0] byp_addr,
  input  logic [DATA_WIDTH-1:0] byp_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

`ifndef REGFILE_BYPASS_EN
  // Forwarding inputs are only consumed when the bypass is compiled in.
  logic unused_byp;
  assign unused_byp = ^{byp_valid, byp_addr, byp_data};
`endif

  // Disabled port or x0 reads as zero; otherwise storage (or forwarded write).
  always_comb begin
    rd_data = '0;
    if (rd_en && (rd_addr != '0)) begin
`ifdef REGFILE_BYPASS_EN
      if (byp_valid && (byp_addr == rd_addr)) begin
        rd_data = byp_data;
      end else begin
        rd_data = stored_data;
      end
`else
      rd_data = stored_data;
`endif
    end
  end

endmodule

// File: rtl/riscv_register_file.sv
// Integer register file: x1..x31 storage, x0 hardwired to zero, one synchronous
// write port, two combinational read ports. Define REGFILE_BYPASS_EN to forward
// the in-flight write to matching read ports in the same cycle.
module riscv_register_file
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = XLEN,
  parameter int unsigned ADDR_WIDTH = REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,     // active-low, asynchronous
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en1,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  output logic [DATA_WIDTH-1:0] rd_data1,
  input  logic                  rd_en2,
  input  logic [ADDR_WIDTH-1:0] rd_addr2,
  output logic [DATA_WIDTH-1:0] rd_data2
);

  localparam int unsigned RegCount = 2 ** ADDR_WIDTH;

  // No entry for x0: it has no storage.
  logic [DATA_WIDTH-1:0] regs_q [1:RegCount-1];
  logic [DATA_WIDTH-1:0] stored1, stored2;
  logic                  wr_fire;
  logic                  byp_valid;

  assign wr_fire   = wr_en && (wr_addr != '0);
  // Never forward while reset holds the storage at zero.
  assign byp_valid = wr_fire && reset;

  // Storage: async clear on reset, commit non-x0 writes on the rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < RegCount; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_fire) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Storage lookup for both ports; x0 has no entry so it is selected as zero here.
  always_comb begin
    stored1 = '0;
    stored2 = '0;
    if (rd_addr1 != '0) stored1 = regs_q[rd_addr1];
    if (rd_addr2 != '0) stored2 = regs_q[rd_addr2];
  end

  regfile_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_port1 (
    .rd_en      (rd_en1),
    .rd_addr    (rd_addr1),
    .stored_data(stored1),
    .byp_valid  (byp_valid),
    .byp_addr   (wr_addr),
    .byp_data   (wr_data),
    .rd_data    (rd_data1)
  );

  regfile_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_port2 (
    .rd_en      (rd_en2),
    .rd_addr    (rd_addr2),
    .stored_data(stored2),
    .byp_valid  (byp_valid),
    .byp_addr   (wr_addr),
    .byp_data   (wr_data),
    .rd_data    (rd_data2)
  );

endmodule

// File: tb/tb_riscv_register_file.sv
// Scoreboard bench for riscv_register_file: directed scenarios then random traffic,
// checked against an array model of the register file.
module tb_riscv_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_en1, rd_en2;
  logic [4:0]  rd_addr1, rd_addr2;
  logic [31:0] rd_data1, rd_data2;

  riscv_register_file dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en1  (rd_en1),
    .rd_addr1(rd_addr1),
    .rd_data1(rd_data1),
    .rd_en2  (rd_en2),
    .rd_addr2(rd_addr2),
    .rd_data2(rd_data2)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem [32];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          stim_done = 1'b0;

  // Reference read: what the architecture says a port shows right now.
  function automatic logic [31:0] model_read(input bit en, input logic [4:0] addr);
    if (!en || addr == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (reset && wr_en && wr_addr == addr) return wr_data;
`endif
    return mem[addr];
  endfunction

  // Drive one cycle of inputs between edges, queue the expected outputs, let the
  // following rising edge commit the write into the model.
  task automatic step(input string name, input bit rst, input bit we, input logic [4:0] wa,
                      input logic [31:0] wd, input bit e1, input logic [4:0] a1,
                      input bit e2, input logic [4:0] a2);
    exp_t e;
    reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en1 = e1; rd_addr1 = a1; rd_en2 = e2; rd_addr2 = a2;
    if (!rst) foreach (mem[i]) mem[i] = 32'd0;
    e.name = name;
    e.e1 = model_read(e1, a1);
    e.e2 = model_read(e2, a2);
    sb_q.push_back(e);
    @(negedge clk);
    @(posedge clk);
    if (rst && we && wa != 5'd0) mem[wa] = wd;
    #2;
  endtask

  // Monitor: every falling edge, compare outputs against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if (rd_data1 !== e.e1) begin
          n_fail++;
          $display("FAIL %s port1: got %h expected %h", e.name, rd_data1, e.e1);
        end
        n_checks++;
        if (rd_data2 !== e.e2) begin
          n_fail++;
          $display("FAIL %s port2: got %h expected %h", e.name, rd_data2, e.e2);
        end
      end
    end
  end

  initial begin
    foreach (mem[i]) mem[i] = 32'd0;
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en1 = 1'b0; rd_addr1 = '0; rd_en2 = 1'b0; rd_addr2 = '0;
    #2;
    step("reset_state",   0, 0, 5'd0,  32'h0,        1, 5'd1,  1, 5'd31);
    step("write_in_rst",  0, 1, 5'd4,  32'h5555AAAA, 1, 5'd4,  1, 5'd4);
    step("after_rst_x4",  1, 0, 5'd0,  32'h0,        1, 5'd4,  0, 5'd4);
    step("wr_x0",         1, 1, 5'd0,  32'hDEADBEEF, 1, 5'd0,  1, 5'd0);
    step("rd_x0",         1, 0, 5'd0,  32'h0,        1, 5'd0,  1, 5'd0);
    step("wr_x5",         1, 1, 5'd5,  32'h12345678, 1, 5'd5,  1, 5'd5);
    step("wr_x31",        1, 1, 5'd31, 32'hCAFEF00D, 1, 5'd5,  1, 5'd31);
    step("rd_x5_x31",     1, 0, 5'd0,  32'h0,        1, 5'd5,  1, 5'd31);
    step("dis_port1",     1, 0, 5'd0,  32'h0,        0, 5'd5,  1, 5'd5);
    step("en_port1",      1, 0, 5'd0,  32'h0,        1, 5'd5,  0, 5'd31);
    step("wr_x7",         1, 1, 5'd7,  32'hA5A5A5A5, 1, 5'd7,  1, 5'd5);
    step("rd_x7",         1, 0, 5'd0,  32'h0,        1, 5'd7,  1, 5'd7);
    step("async_rst",     0, 0, 5'd0,  32'h0,        1, 5'd7,  1, 5'd5);
    step("x7_after_rst",  1, 0, 5'd0,  32'h0,        1, 5'd7,  1, 5'd31);
    step("wr_x9_old",     1, 1, 5'd9,  32'h11111111, 1, 5'd9,  1, 5'd1);
    step("wr_x9_same",    1, 1, 5'd9,  32'h22222222, 1, 5'd9,  1, 5'd9);
    step("rd_x9_new",     1, 0, 5'd9,  32'h33333333, 1, 5'd9,  1, 5'd9);
    for (int i = 0; i < 4; i++) begin
      step("wr_en0_x3",   1, 0, 5'd3,  32'hFFFFFFFF, 1, 5'd3,  1, 5'd3);
    end
    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      step("random",
           ($urandom_range(0, 39) != 0),
           ($urandom_range(0, 3) != 0),
           5'($urandom_range(0, 31)),
           $urandom(),
           ($urandom_range(0, 4) != 0),
           5'($urandom_range(0, 31)),
           ($urandom_range(0, 4) != 0),
           5'($urandom_range(0, 31)));
    end
    stim_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got stim_done=%0d expected 1", stim_done);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
